// File: rtl/cam_array_ctrl_if.sv
// Request/response handshake bundle between a system-side client and the CAM controller.
// The client uses the master modport and the controller uses the slave modport.
interface cam_array_ctrl_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic [AW-1:0]    rsp_addr;
  logic             rsp_multi;

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_multi
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_multi
  );
endinterface

// File: rtl/cam_array_ctrl.sv
// CAM array controller: sequences word-line write cycles and precharge/evaluate/sample
// search cycles onto a WORDS x WIDTH CAM array, with a priority-encoded search result.
module cam_array_ctrl #(
  parameter int WORDS       = 8,
  parameter int WIDTH       = 8,
  parameter int AW          = $clog2(WORDS),
  parameter int WR_CYCLES   = 2,
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cam_array_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] DL,
  output logic [WIDTH-1:0] DLB,
  output logic [WORDS-1:0] WLWR,
  output logic [WIDTH-1:0] CAMData,
  output logic             ML_PRE,
  input  logic [WORDS-1:0] MATCH,
  output logic             busy
);

  localparam int MAXC_A = (WR_CYCLES > PRE_CYCLES) ? WR_CYCLES : PRE_CYCLES;
  localparam int MAXC   = (MAXC_A > EVAL_CYCLES) ? MAXC_A : EVAL_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, S_PRE, S_EVAL, S_SAMPLE, S_RESP
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [AW-1:0]    addr_q, addr_nx;
  logic [WIDTH-1:0] data_q, data_nx;
  logic             accept;
  logic [WIDTH-1:0] dl_nx, cam_nx;
  logic [WORDS-1:0] wl_nx;

  function automatic logic [AW-1:0] lowest_idx(input logic [WORDS-1:0] m);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (m[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [WORDS-1:0] m);
    return (m & (m - WORDS'(1))) != '0;
  endfunction

  // Next state and the shared duty-cycle counter, reloaded on every timed-state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = (state == IDLE) && bus.req_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_op) begin
            state_nx = WR_SETUP;
          end else begin
            state_nx = S_PRE;
            cnt_nx   = CW'(PRE_CYCLES - 1);
          end
        end
      end
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_nx   = CW'(WR_CYCLES - 1);
      end
      WR_PULSE: begin
        if (cnt == '0) state_nx = WR_HOLD;
        else           cnt_nx   = cnt - CW'(1);
      end
      WR_HOLD:  state_nx = IDLE;
      S_PRE: begin
        if (cnt == '0) begin
          state_nx = S_EVAL;
          cnt_nx   = CW'(EVAL_CYCLES - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_EVAL: begin
        if (cnt == '0) state_nx = S_SAMPLE;
        else           cnt_nx   = cnt - CW'(1);
      end
      S_SAMPLE: state_nx = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so each flop reflects the state it lives in
  always_comb begin
    addr_nx = accept ? bus.req_addr : addr_q;
    data_nx = accept ? bus.req_data : data_q;
    dl_nx   = '0;
    cam_nx  = '0;
    wl_nx   = '0;
    if (state_nx == WR_SETUP || state_nx == WR_PULSE || state_nx == WR_HOLD) dl_nx = data_nx;
    if (state_nx == WR_PULSE) wl_nx = WORDS'(1) << addr_nx;
    if (state_nx == S_PRE || state_nx == S_EVAL || state_nx == S_SAMPLE) cam_nx = data_nx;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_nx;
    data_q <= data_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      DL            <= '0;
      DLB           <= '1;
      WLWR          <= '0;
      CAMData       <= '0;
      ML_PRE        <= 1'b0;
      busy          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_multi <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      DL            <= dl_nx;
      DLB           <= ~dl_nx;
      WLWR          <= wl_nx;
      CAMData       <= cam_nx;
      ML_PRE        <= (state_nx == S_PRE);
      busy          <= (state_nx != IDLE);
      bus.req_ready <= (state_nx == IDLE);
      bus.rsp_valid <= (state_nx == S_RESP);
      if (state == S_SAMPLE) begin
        bus.rsp_hit   <= |MATCH;
        bus.rsp_addr  <= lowest_idx(MATCH);
        bus.rsp_multi <= more_than_one(MATCH);
      end
    end
  end

endmodule

// File: tb/tb_cam_array_ctrl.sv
// Directed bench for cam_array_ctrl: write/search sequencing, result encoding, stalls,
// back-to-back requests and asynchronous reset mid-write.
module tb_cam_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] DL, DLB, WLWR, CAMData, MATCH;
  logic       ML_PRE, busy;
  logic [7:0] dl_inv;
  int         total = 0;
  int         bad = 0;

  cam_array_ctrl_if #(.AW(3), .WIDTH(8)) bus();

  cam_array_ctrl #(
    .WORDS(8), .WIDTH(8), .AW(3), .WR_CYCLES(2), .PRE_CYCLES(1), .EVAL_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .DL(DL), .DLB(DLB), .WLWR(WLWR), .CAMData(CAMData), .ML_PRE(ML_PRE),
    .MATCH(MATCH), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Array-side invariants checked every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      dl_inv = ~DL;
      chk("dlb_inv", DLB, dl_inv);
      chk("wl_ml_excl", 32'(ML_PRE & (|WLWR)), 0);
      chk("wl_onehot", 32'($countones(WLWR) <= 1), 1);
    end
  end

  task automatic run_search(input logic [7:0] key, input logic [7:0] m,
                            input logic hit, input logic [2:0] a, input logic mu);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_addr  = 3'd6;
    bus.req_data  = key;
    MATCH         = 8'hFF;
    tick();
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    for (int j = 0; j < 4; j++) begin
      chk("s_mlpre", 32'(ML_PRE), 32'(j == 0));
      chk("s_camdata", CAMData, key);
      chk("s_early_valid", 32'(bus.rsp_valid), 0);
      chk("s_ready_low", 32'(bus.req_ready), 0);
      if (j == 3) MATCH = m;
      tick();
    end
    MATCH = 8'hFF;
    chk("s_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("s_hit", 32'(bus.rsp_hit), 32'(hit));
    chk("s_addr", 32'(bus.rsp_addr), 32'(a));
    chk("s_multi", 32'(bus.rsp_multi), 32'(mu));
    chk("s_cam_idle", CAMData, 8'h00);
  endtask

  task automatic consume(input logic hit, input logic [2:0] a);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("c_valid_drop", 32'(bus.rsp_valid), 0);
    chk("c_ready", 32'(bus.req_ready), 1);
    chk("c_hit_held", 32'(bus.rsp_hit), 32'(hit));
    chk("c_addr_held", 32'(bus.rsp_addr), 32'(a));
  endtask

  initial begin
    int pulses;
    int lows;
    logic [7:0] wl_exp, dl_exp;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_addr  = 3'd0;
    bus.req_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    MATCH         = 8'h00;
    repeat (2) tick();

    chk("rst_dl", DL, 8'h00);
    chk("rst_dlb", DLB, 8'hFF);
    chk("rst_wlwr", WLWR, 8'h00);
    chk("rst_camdata", CAMData, 8'h00);
    chk("rst_mlpre", 32'(ML_PRE), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_hit", 32'(bus.rsp_hit), 0);
    chk("rst_rsp_addr", 32'(bus.rsp_addr), 0);
    chk("rst_rsp_multi", 32'(bus.rsp_multi), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(bus.req_ready), 1);

    // Write 0xA5 to word 3
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd3;
    bus.req_data  = 8'hA5;
    tick();
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.req_addr  = 3'd0;
    chk("wr_dlb", DLB, 8'h5A);
    pulses = 0;
    lows   = 0;
    for (int j = 0; j < 5; j++) begin
      wl_exp = (j == 1 || j == 2) ? 8'h08 : 8'h00;
      dl_exp = (j <= 3) ? 8'hA5 : 8'h00;
      chk("wr_wlwr", WLWR, wl_exp);
      chk("wr_dl", DL, dl_exp);
      chk("wr_ready", 32'(bus.req_ready), 32'(j == 4));
      chk("wr_no_rsp", 32'(bus.rsp_valid), 0);
      if (WLWR == 8'h08) pulses++;
      if (!bus.req_ready) lows++;
      tick();
    end
    chk("wr_pulse_cycles", pulses, 2);
    chk("wr_ready_low_cycles", lows, 4);

    run_search(8'hA5, 8'h08, 1'b1, 3'd3, 1'b0);
    consume(1'b1, 3'd3);

    run_search(8'h5A, 8'h00, 1'b0, 3'd0, 1'b0);
    consume(1'b0, 3'd0);

    // Multi-hit result stalled for 5 cycles with a competing request pending
    run_search(8'hC3, 8'h94, 1'b1, 3'd2, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd7;
    bus.req_data  = 8'h11;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("st_valid", 32'(bus.rsp_valid), 1);
      chk("st_addr", 32'(bus.rsp_addr), 2);
      chk("st_multi", 32'(bus.rsp_multi), 1);
      chk("st_ready", 32'(bus.req_ready), 0);
      chk("st_wlwr", WLWR, 8'h00);
    end
    bus.req_valid = 1'b0;
    consume(1'b1, 3'd2);
    tick();
    chk("st_no_write", 32'(busy), 0);

    // Back-to-back: write word 5, then a search accepted on IDLE re-entry
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd5;
    bus.req_data  = 8'h3C;
    MATCH         = 8'h00;
    tick();
    bus.req_op = 1'b0;
    tick();
    chk("bb_wlwr", WLWR, 8'h20);
    repeat (3) tick();
    chk("bb_idle_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    chk("bb_mlpre", 32'(ML_PRE), 1);
    chk("bb_camdata", CAMData, 8'h3C);
    chk("bb_ready_low", 32'(bus.req_ready), 0);
    MATCH = 8'h20;
    repeat (4) tick();
    chk("bb_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("bb_rsp_addr", 32'(bus.rsp_addr), 5);
    chk("bb_rsp_multi", 32'(bus.rsp_multi), 0);
    consume(1'b1, 3'd5);

    // Asynchronous reset in the middle of WR_PULSE
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd1;
    bus.req_data  = 8'h0F;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("ar_wlwr_pulse", WLWR, 8'h02);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_wlwr", WLWR, 8'h00);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_dl", DL, 8'h00);
    chk("ar_dlb", DLB, 8'hFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_ready", 32'(bus.req_ready), 1);
    chk("ar_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("ar_busy_after", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_array_ctrl.md
Name: cam_array_ctrl

Overview:
- Controller that drives the CAM cell array from the system side.
- Sequences write cycles onto the array: drives DL/DLB data lines and pulses one WLWR word line.
- Sequences search cycles: drives CAMData search lines, precharges the match lines, samples the per-word MATCH lines, and priority-encodes the result.
- Sits between a valid/ready request interface and the WORDS x WIDTH array of CAM cells.

Parameters:
- WORDS, 8, number of CAM words (rows); power of two, at least 2.
- WIDTH, 8, bits per word (columns).
- AW, clog2(WORDS), address width.
- WR_CYCLES, 2, number of cycles WLWR is held high per write; at least 1.
- PRE_CYCLES, 1, number of match-line precharge cycles; at least 1.
- EVAL_CYCLES, 2, number of match-line evaluate cycles before sampling; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  1  0 = search, 1 = write.
- req_addr  in  AW  target word for a write; ignored for a search.
- req_data  in  WIDTH  write data or search key.
- DL  out  WIDTH  true data lines to the array.
- DLB  out  WIDTH  complement data lines to the array.
- WLWR  out  WORDS  one-hot write word lines.
- CAMData  out  WIDTH  search lines.
- ML_PRE  out  1  match-line precharge enable.
- MATCH  in  WORDS  per-word match lines; 1 = word matches.
- rsp_valid  out  1  search result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hit  out  1  at least one word matched.
- rsp_addr  out  AW  lowest matching index.
- rsp_multi  out  1  more than one word matched.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - State = IDLE.
  - DL = 0, DLB = all ones, WLWR = 0, CAMData = 0, ML_PRE = 0.
  - rsp_valid = 0, rsp_hit = 0, rsp_addr = 0, rsp_multi = 0, busy = 0.
  - req_ready = 1 once reset is released.
- Registered outputs: every output is driven from a flop.
- DLB: always the bitwise inverse of DL, in every state including reset.
- req_ready: 1 only in IDLE. A request is accepted when req_valid && req_ready at a rising edge. req_op, req_addr and req_data are latched on acceptance and held for the whole operation.
- FSM states and transitions:
  - IDLE
    - Accept with req_op = 1 goes to WR_SETUP.
    - Accept with req_op = 0 goes to S_PRE.
  - WR_SETUP: 1 cycle. DL = data, WLWR = 0. Next: WR_PULSE.
  - WR_PULSE: WR_CYCLES cycles. WLWR[addr] = 1, all other bits 0. Next: WR_HOLD.
  - WR_HOLD: 1 cycle. WLWR = 0, DL still held. Next: IDLE.
  - Write duration: WR_CYCLES + 2 cycles from acceptance to req_ready = 1. A write produces no response.
  - S_PRE: PRE_CYCLES cycles. CAMData = key, ML_PRE = 1. Next: S_EVAL.
  - S_EVAL: EVAL_CYCLES cycles. ML_PRE = 0, CAMData held. Next: S_SAMPLE.
  - S_SAMPLE: 1 cycle. Register MATCH and compute:
    - rsp_hit = |MATCH.
    - rsp_addr = lowest set index, or 0 if none.
    - rsp_multi = popcount(MATCH) > 1.
    - Next: S_RESP.
  - S_RESP: rsp_valid = 1, result fields stable. On rsp_ready, rsp_valid drops and the FSM returns to IDLE.
- Search latency: rsp_valid asserts PRE_CYCLES + EVAL_CYCLES + 1 cycles after acceptance. Defaults give 4.
- Response stalls: S_RESP waits indefinitely while rsp_ready = 0; no new request is accepted during the wait.
- Result hold: rsp_* fields hold their values after the handshake until the next S_SAMPLE.
- CAMData: driven only in S_PRE, S_EVAL and S_SAMPLE; 0 otherwise.
- Mutual exclusion: WLWR and ML_PRE are never high together.
- WLWR: never more than one bit high.
- Duty-cycle counter: a single shared down-counter times WR_PULSE, S_PRE and S_EVAL. It reloads on each state entry, and its width is sized to the largest parameter.
- MATCH sampling: sampled only in S_SAMPLE; changes in any other state are ignored.
- Reset during an operation: all outputs return to their reset values immediately. This drops WLWR mid-pulse (the write is lost) and clears any pending response.
- Out-of-range req_addr (when WORDS is below 2^AW): not possible for power-of-two WORDS; no check is required.

Test Plan:
- Reset, then write addr 3, data 0xA5 -> WLWR = 0x08 for exactly 2 cycles, DL = 0xA5 and DLB = 0x5A from WR_SETUP through WR_HOLD, req_ready low for 4 cycles.
- Search key 0xA5 with bench MATCH = 0x08 -> ML_PRE high 1 cycle, rsp_valid 4 cycles after acceptance, rsp_hit = 1, rsp_addr = 3, rsp_multi = 0.
- Search with MATCH = 0x00 -> rsp_hit = 0, rsp_addr = 0, rsp_multi = 0.
- Search with MATCH = 0x94 -> rsp_addr = 2, rsp_multi = 1; hold rsp_ready low 5 cycles -> rsp_valid and fields stable, req_ready = 0 throughout.
- Back-to-back write then search with req_valid held high -> second request accepted the cycle IDLE is re-entered; WLWR and ML_PRE are never high together.
- Assert rst_n low during WR_PULSE -> WLWR = 0 and busy = 0 immediately; after release, req_ready = 1 and rsp_valid = 0.
